// File: rtl/ecfs_sync_pkg.sv
// ecfs_sync_pkg
// Shared definitions for the ecfs_sync_pulse_gen carrier/sync generator:
//   - ecfs_state_e : carrier direction state (IDLE, UP, DOWN)
//   - ECFS_P_MIN   : smallest usable half-period; smaller period requests clamp here
//   - ECFS_CNT_W / ECFS_DEC_W : default counter and decimation widths
package ecfs_sync_pkg;

    localparam int ECFS_CNT_W = 16;
    localparam int ECFS_DEC_W = 4;
    localparam int ECFS_P_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } ecfs_state_e;

endpackage

// File: rtl/ecfs_sync_decim.sv
// ecfs_sync_decim
// Decimation counter for the carrier sync pulse. Every sync_event either fires
// a one-cycle pulse (counter at zero, then reloaded from decim) or counts down.
// clear forces the counter to zero so the first event afterwards always fires.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   sync_event     : one sync event to be decimated (single cycle)
//   decim          : pulse every decim+1 events; sampled only on reload
//   clear          : synchronous clear of counter and pulse
//   pulse          : registered one-cycle pulse
module ecfs_sync_decim import ecfs_sync_pkg::*; #(
    parameter int DEC_W = ECFS_DEC_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_event,
    input  logic [DEC_W-1:0] decim,
    input  logic             clear,
    output logic             pulse
);

    logic [DEC_W-1:0] dcnt_r;
    logic             pulse_r;

    // Decimation counter and registered pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt_r  <= '0;
            pulse_r <= 1'b0;
        end else if (clear) begin
            dcnt_r  <= '0;
            pulse_r <= 1'b0;
        end else if (sync_event) begin
            if (dcnt_r == '0) begin
                pulse_r <= 1'b1;
                dcnt_r  <= decim;
            end else begin
                pulse_r <= 1'b0;
                dcnt_r  <= dcnt_r - DEC_W'(1);
            end
        end else begin
            pulse_r <= 1'b0;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/ecfs_sync_pulse_gen.sv
// ecfs_sync_pulse_gen
// Symmetric up/down triangle carrier (0..P..1, period 2P) with a decimated
// one-cycle sync pulse at the valley. The half-period is shadowed at valleys
// so period updates never truncate a running ramp.
// Build option: define ECFS_SYNC_PEAK_EN to make carrier peaks sync events too
// (pulse in the cycle carrier==P, same decimation counter).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : run request; low returns to IDLE on the next edge
//   period       : requested half-period P (clamped to >= 2 when loaded)
//   decim        : pulse every decim+1 sync events
//   sync_in      : external sync; a rising edge restarts the carrier at 0
//   sync_out     : registered one-cycle sync pulse
//   carrier      : registered triangle counter
//   dir_down     : registered, 1 while counting down
module ecfs_sync_pulse_gen import ecfs_sync_pkg::*; #(
    parameter int CNT_W = ECFS_CNT_W,
    parameter int DEC_W = ECFS_DEC_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [DEC_W-1:0] decim,
    input  logic             sync_in,
    output logic             sync_out,
    output logic [CNT_W-1:0] carrier,
    output logic             dir_down
);

`ifdef ECFS_SYNC_PEAK_EN
    localparam logic PEAK_SYNC = 1'b1;
`else
    localparam logic PEAK_SYNC = 1'b0;
`endif

    ecfs_state_e      state_r;
    logic [CNT_W-1:0] carrier_r;
    logic [CNT_W-1:0] p_shadow_r;
    logic             dir_down_r;
    // High in the cycle right after an event has been evaluated; a sync edge
    // landing in that cycle merges with it instead of pulsing a second time.
    logic             ev_r;
    logic             sync_d1_r;
    logic             sync_d2_r;

    logic             rise_s;
    logic [CNT_W-1:0] p_load_s;
    logic             enter_s;
    logic             sync_ev_s;
    logic             turn_s;
    logic             peak_s;
    logic             decim_ev_s;
    logic             clear_s;

    // Two-stage sync_in delay line; the edge is taken between the two stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_d1_r <= 1'b0;
            sync_d2_r <= 1'b0;
        end else begin
            sync_d1_r <= sync_in;
            sync_d2_r <= sync_d1_r;
        end
    end

    // Event detection and the decimator's event strobe
    always_comb begin
        rise_s    = sync_d1_r & ~sync_d2_r;
        p_load_s  = (period < CNT_W'(ECFS_P_MIN)) ? CNT_W'(ECFS_P_MIN) : period;
        enter_s   = enable && (state_r == ST_IDLE);
        sync_ev_s = enable && (state_r != ST_IDLE) && rise_s;
        // Natural valley and peak are evaluated on the edge that makes the
        // carrier show 0 / P, so the pulse lines up with that value.
        turn_s    = enable && (state_r == ST_DOWN) && (carrier_r == CNT_W'(1));
        peak_s    = enable && (state_r == ST_UP) && (carrier_r == (p_shadow_r - CNT_W'(1)));
        clear_s   = ~enable;
        if (enter_s) begin
            decim_ev_s = 1'b1;
        end else if (sync_ev_s) begin
            decim_ev_s = ~ev_r;
        end else if (turn_s) begin
            decim_ev_s = 1'b1;
        end else if (peak_s) begin
            decim_ev_s = PEAK_SYNC;
        end else begin
            decim_ev_s = 1'b0;
        end
    end

    // Carrier FSM: direction, counter, period shadow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            carrier_r  <= '0;
            p_shadow_r <= CNT_W'(ECFS_P_MIN);
            dir_down_r <= 1'b0;
            ev_r       <= 1'b0;
        end else if (!enable) begin
            state_r    <= ST_IDLE;
            carrier_r  <= '0;
            dir_down_r <= 1'b0;
            ev_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_UP;
                    carrier_r  <= '0;
                    p_shadow_r <= p_load_s;
                    dir_down_r <= 1'b0;
                    ev_r       <= 1'b1;
                end
                ST_UP, ST_DOWN: begin
                    if (rise_s) begin
                        state_r    <= ST_UP;
                        carrier_r  <= '0;
                        p_shadow_r <= p_load_s;
                        dir_down_r <= 1'b0;
                        ev_r       <= 1'b1;
                    end else if (state_r == ST_UP) begin
                        if (carrier_r == p_shadow_r) begin
                            state_r    <= ST_DOWN;
                            carrier_r  <= p_shadow_r - CNT_W'(1);
                            dir_down_r <= 1'b1;
                            ev_r       <= 1'b0;
                        end else begin
                            carrier_r <= carrier_r + CNT_W'(1);
                            ev_r      <= peak_s & PEAK_SYNC;
                        end
                    end else begin
                        if (carrier_r == '0) begin
                            // Valley cycle already evaluated; turn around
                            state_r    <= ST_UP;
                            carrier_r  <= CNT_W'(1);
                            dir_down_r <= 1'b0;
                            ev_r       <= 1'b0;
                        end else if (carrier_r == CNT_W'(1)) begin
                            carrier_r  <= '0;
                            p_shadow_r <= p_load_s;
                            ev_r       <= 1'b1;
                        end else begin
                            carrier_r <= carrier_r - CNT_W'(1);
                            ev_r      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    carrier_r  <= '0;
                    dir_down_r <= 1'b0;
                    ev_r       <= 1'b0;
                end
            endcase
        end
    end

    ecfs_sync_decim #(
        .DEC_W (DEC_W)
    ) u_decim (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_event (decim_ev_s),
        .decim      (decim),
        .clear      (clear_s),
        .pulse      (sync_out)
    );

    assign carrier  = carrier_r;
    assign dir_down = dir_down_r;

endmodule

// File: tb/tb_ecfs_sync_pulse_gen.sv
// tb_ecfs_sync_pulse_gen
// Self-checking bench for ecfs_sync_pulse_gen: a constant vector table for the
// basic ramp, hand-written multi-cycle corner sequences, and a randomized run
// against a position-within-period reference model.
module tb_ecfs_sync_pulse_gen;

`ifdef ECFS_SYNC_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] period;
    logic [3:0]  decim;
    logic        sync_in;
    logic        sync_out;
    logic [15:0] carrier;
    logic        dir_down;

    int checks;
    int errors;
    logic prev_so;

    ecfs_sync_pulse_gen dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .period   (period),
        .decim    (decim),
        .sync_in  (sync_in),
        .sync_out (sync_out),
        .carrier  (carrier),
        .dir_down (dir_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position inside the current carrier period
    bit m_idle;
    int m_pos;
    int m_p;
    int m_dcnt;
    bit m_ev;
    bit m_so;
    bit m_dir0;
    bit m_s1;
    bit m_s2;

    function automatic int clamp_p(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic bit decide(input int d);
        if (m_dcnt == 0) begin
            m_dcnt = d;
            return 1'b1;
        end else begin
            m_dcnt = m_dcnt - 1;
            return 1'b0;
        end
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_pos = 0; m_p = 2; m_dcnt = 0; m_ev = 1'b0;
        m_so = 1'b0; m_dir0 = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_edge(input bit en, input int p, input int d, input bit s);
        bit rise;
        rise = m_s1 & ~m_s2;
        m_s2 = m_s1;
        m_s1 = s;
        if (!en) begin
            m_idle = 1'b1; m_pos = 0; m_so = 1'b0; m_dcnt = 0; m_ev = 1'b0; m_dir0 = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0; m_pos = 0; m_p = clamp_p(p); m_dir0 = 1'b0;
            m_so = decide(d); m_ev = 1'b1;
        end else if (rise) begin
            m_pos = 0; m_p = clamp_p(p); m_dir0 = 1'b0;
            m_so = m_ev ? 1'b0 : decide(d);
            m_ev = 1'b1;
        end else begin
            m_pos = (m_pos + 1) % (2 * m_p);
            if (m_pos == 0) begin
                m_p = clamp_p(p); m_dir0 = 1'b1; m_so = decide(d); m_ev = 1'b1;
            end else if (PEAK_EN && m_pos == m_p) begin
                m_so = decide(d); m_ev = 1'b1;
            end else begin
                m_so = 1'b0; m_ev = 1'b0;
            end
        end
    endtask

    function automatic int m_carrier();
        return (m_pos <= m_p) ? m_pos : 2 * m_p - m_pos;
    endfunction

    function automatic bit m_dir();
        return (m_pos == 0) ? m_dir0 : (m_pos > m_p);
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, compare after the rising edge
    task automatic step(input bit en, input int p, input int d, input bit s);
        enable = en; period = 16'(p); decim = 4'(d); sync_in = s;
        @(posedge clk);
        model_edge(en, p, d, s);
        #1;
        check_eq("model_carrier", int'(carrier), m_carrier());
        check_eq("model_sync_out", int'(sync_out), int'(m_so));
        check_eq("model_dir_down", int'(dir_down), int'(m_dir()));
        if (prev_so) check_eq("no_double_pulse", int'(sync_out), 0);
        prev_so = sync_out;
        @(negedge clk);
    endtask

    typedef struct {
        bit en; int p; int d; bit s;
        int c; bit so; bit dir; bit pk;
    } vec_t;

    function automatic vec_t mk(input bit en, input int p, input int d, input bit s,
                                input int c, input bit so, input bit dir, input bit pk);
        vec_t v;
        v.en = en; v.p = p; v.d = d; v.s = s; v.c = c; v.so = so; v.dir = dir; v.pk = pk;
        return v;
    endfunction

    initial begin
        vec_t tbl[11];
        int   car[16];
        int   npulse;
        int   first_i;
        int   second_i;
        bit   rs;
        int   rp;
        int   rd;

        checks = 0; errors = 0; prev_so = 1'b0;
        reset_n = 1'b0; enable = 1'b0; period = 16'd4; decim = 4'd0; sync_in = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_eq("reset_carrier", int'(carrier), 0);
        check_eq("reset_sync_out", int'(sync_out), 0);
        check_eq("reset_dir_down", int'(dir_down), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic ramp P=4, decim=0, starting from IDLE
        tbl[0]  = mk(1'b1, 4, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 4, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 4, 0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 4, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 4, 0, 1'b0, 4, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(1'b1, 4, 0, 1'b0, 3, 1'b0, 1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 4, 0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 4, 0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 4, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 4, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 4, 0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].p, tbl[i].d, tbl[i].s);
            check_eq($sformatf("tbl%0d_carrier", i), int'(carrier), tbl[i].c);
            check_eq($sformatf("tbl%0d_sync_out", i), int'(sync_out),
                     int'(tbl[i].so | (PEAK_EN & tbl[i].pk)));
            check_eq($sformatf("tbl%0d_dir_down", i), int'(dir_down), int'(tbl[i].dir));
        end

        // decim=2: pulse on every third event
        step(1'b0, 4, 2, 1'b0);
        npulse = 0; first_i = -1; second_i = -1;
        for (int i = 0; i < 72; i++) begin
            step(1'b1, 4, 2, 1'b0);
            if (sync_out) begin
                npulse++;
                if (first_i < 0) first_i = i;
                else if (second_i < 0) second_i = i;
            end
        end
        check_eq("decim2_first", first_i, 0);
        check_eq("decim2_count", npulse, PEAK_EN ? 6 : 3);
        check_eq("decim2_spacing", second_i - first_i, PEAK_EN ? 12 : 24);

        // Period 4 -> 6 mid-ramp: current ramp still peaks at 4, next at 6
        step(1'b0, 4, 0, 1'b0);
        step(1'b1, 4, 0, 1'b0);
        car[0] = carrier;
        for (int i = 1; i < 16; i++) begin
            step(1'b1, (i >= 2) ? 6 : 4, 0, 1'b0);
            car[i] = carrier;
        end
        check_eq("pchg_peak4", car[4], 4);
        check_eq("pchg_after_peak4", car[5], 3);
        check_eq("pchg_valley", car[8], 0);
        check_eq("pchg_peak6", car[14], 6);
        check_eq("pchg_after_peak6", car[15], 5);

        // P=0 clamps to 2
        step(1'b0, 0, 0, 1'b0);
        step(1'b1, 0, 0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            step(1'b1, 0, 0, 1'b0);
            car[i] = carrier;
        end
        check_eq("pmin_peak", car[2], 2);
        check_eq("pmin_down", car[3], 1);
        check_eq("pmin_valley", car[4], 0);
        check_eq("pmin_valley_pulse", int'(sync_out), 1);

        // sync_in edge at carrier=3 while UP: restart two cycles later
        step(1'b0, 6, 0, 1'b0);
        step(1'b1, 6, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 6, 0, 1'b0);
        check_eq("sync_pre_carrier", int'(carrier), 3);
        step(1'b1, 6, 0, 1'b1);
        check_eq("sync_lat1_carrier", int'(carrier), 4);
        step(1'b1, 6, 0, 1'b0);
        check_eq("sync_lat2_carrier", int'(carrier), 0);
        check_eq("sync_lat2_pulse", int'(sync_out), 1);
        check_eq("sync_lat2_dir", int'(dir_down), 0);

        // sync_in coincident with the natural valley edge: one pulse
        step(1'b0, 4, 0, 1'b0);
        step(1'b1, 4, 0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 4, 0, 1'b0);
        step(1'b1, 4, 0, 1'b1);
        step(1'b1, 4, 0, 1'b0);
        check_eq("coinc_carrier", int'(carrier), 0);
        check_eq("coinc_pulse", int'(sync_out), 1);
        step(1'b1, 4, 0, 1'b0);
        check_eq("coinc_next_pulse", int'(sync_out), 0);

        // sync_in edge landing in the valley cycle merges with it
        step(1'b0, 4, 0, 1'b0);
        step(1'b1, 4, 0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 4, 0, 1'b0);
        step(1'b1, 4, 0, 1'b1);
        check_eq("merge_valley_pulse", int'(sync_out), 1);
        step(1'b1, 4, 0, 1'b0);
        check_eq("merge_carrier", int'(carrier), 0);
        check_eq("merge_no_pulse", int'(sync_out), 0);

        // enable dropped at carrier=3, re-enable pulses despite decim=2
        step(1'b0, 4, 2, 1'b0);
        step(1'b1, 4, 2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4, 2, 1'b0);
        step(1'b0, 4, 2, 1'b0);
        check_eq("dis_carrier", int'(carrier), 0);
        check_eq("dis_sync_out", int'(sync_out), 0);
        check_eq("dis_dir", int'(dir_down), 0);
        step(1'b1, 4, 2, 1'b0);
        check_eq("reen_pulse", int'(sync_out), 1);

        // Randomized run with one asynchronous reset mid-operation
        rs = 1'b0; rp = 5; rd = 1;
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) begin
                reset_n = 1'b0;
                #1;
                check_eq("midrst_carrier", int'(carrier), 0);
                check_eq("midrst_sync_out", int'(sync_out), 0);
                check_eq("midrst_dir", int'(dir_down), 0);
                model_reset();
                prev_so = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) rp = $urandom_range(0, 9);
            if ($urandom_range(0, 29) == 0) rd = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            step($urandom_range(0, 99) < 97, rp, rd, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
